// File: rtl/mc_req_fifo_pkg.sv
// mc_req_fifo_pkg: shared types for the multi-channel request FIFO.
//   req_pkt_type - request packet carried through every channel FIFO
//   ch_idx_t     - channel index wide enough for the largest channel count
//   gnt_state_e  - output grant lock state
package mc_req_fifo_pkg;

  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef struct packed {
    logic [7:0]  req_id;
    logic [23:0] addr;
    logic        is_wr;
  } req_pkt_type;

  typedef enum logic {
    GNT_OPEN,
    GNT_LOCKED
  } gnt_state_e;

  // Round-robin successor of channel c among n channels.
  function automatic ch_idx_t next_ch(ch_idx_t c, int unsigned n);
    if (32'(c) + 1 >= n) return '0;
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/mc_req_fifo_if.sv
// mc_req_fifo_if: producer/consumer bus of mc_req_fifo.
//   write_in/input_req      per-channel write strobe and packet
//   fifo_full/fifo_afull    per-channel occupancy flags
//   overflow_err            per-channel sticky write-while-full flag
//   out_valid/out_ready     output handshake
//   output_req/out_ch       granted head packet and its channel
// master: producer/consumer side; slave: the FIFO.
interface mc_req_fifo_if
  import mc_req_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned OCW = $clog2(NUM_CH);

  logic        [NUM_CH-1:0] write_in;
  req_pkt_type [NUM_CH-1:0] input_req;
  logic        [NUM_CH-1:0] fifo_full;
  logic        [NUM_CH-1:0] fifo_afull;
  logic        [NUM_CH-1:0] overflow_err;
  logic                     out_valid;
  logic                     out_ready;
  req_pkt_type              output_req;
  logic        [OCW-1:0]    out_ch;

  modport master (
    output write_in, input_req, out_ready,
    input  fifo_full, fifo_afull, overflow_err, out_valid, output_req, out_ch
  );

  modport slave (
    input  write_in, input_req, out_ready,
    output fifo_full, fifo_afull, overflow_err, out_valid, output_req, out_ch
  );

endinterface

// File: rtl/mc_req_fifo_ch.sv
// mc_req_fifo_ch: single-channel circular request buffer.
//   clk, rst_b      clock, synchronous active-low reset
//   wr, wr_data     write strobe and packet (dropped when full)
//   rd              pop strobe (ignored when empty)
//   rd_data         head packet
//   full, afull     count == DEPTH, count >= AFULL_LVL
//   empty           count == 0
//   ovf             sticky: write attempted while full
module mc_req_fifo_ch
  import mc_req_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        wr,
  input  req_pkt_type wr_data,
  input  logic        rd,
  output req_pkt_type rd_data,
  output logic        full,
  output logic        afull,
  output logic        empty,
  output logic        ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  req_pkt_type   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance uses the occupancy at the edge; a same-cycle pop does not
  // make room for a write into a full channel.
  assign wr_acc  = wr & ~full;
  assign rd_acc  = rd & ~empty;

  assign full    = (count == CW'(DEPTH));
  assign afull   = (count >= CW'(AFULL_LVL));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/mc_req_fifo.sv
// mc_req_fifo: NUM_CH independent request FIFOs merged onto one output
// with round-robin arbitration and a grant lock.
//   clk, rst_b  clock, synchronous active-low reset
//   bus         mc_req_fifo_if slave: per-channel writes and flags,
//               out_valid/out_ready/output_req/out_ch output port
module mc_req_fifo
  import mc_req_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst_b,
  mc_req_fifo_if.slave bus
);

  localparam int unsigned OCW = $clog2(NUM_CH);

  req_pkt_type       head [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop_vec;

  gnt_state_e state_q, state_d;
  ch_idx_t    lock_ch_q, lock_ch_d;
  ch_idx_t    rr_ptr_q, rr_ptr_d;
  ch_idx_t    grant;
  ch_idx_t    rr_grant;
  logic       found;
  logic       any_valid;
  logic       pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mc_req_fifo_ch #(
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
    ) u_ch (
      .clk     (clk),
      .rst_b   (rst_b),
      .wr      (bus.write_in[g]),
      .wr_data (bus.input_req[g]),
      .rd      (pop_vec[g]),
      .rd_data (head[g]),
      .full    (bus.fifo_full[g]),
      .afull   (bus.fifo_afull[g]),
      .empty   (empty[g]),
      .ovf     (bus.overflow_err[g])
    );
  end

  assign any_valid = ~&empty;
  assign pop       = any_valid & bus.out_ready;

  // First non-empty channel at or after rr_ptr, with wrap.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!found && !empty[c] && (c == (32'(rr_ptr_q) + i) % NUM_CH)) begin
          found    = 1'b1;
          rr_grant = ch_idx_t'(c);
        end
      end
    end
  end

  // A locked channel cannot drain without a pop, so it is always valid.
  assign grant = (state_q == GNT_LOCKED) ? lock_ch_q : rr_grant;

  always_comb begin
    pop_vec        = '0;
    bus.output_req = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant == ch_idx_t'(c)) begin
        pop_vec[c] = pop;
        if (any_valid) bus.output_req = head[c];
      end
    end
  end

  assign bus.out_valid = any_valid;
  assign bus.out_ch    = any_valid ? OCW'(grant) : '0;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (pop) begin
      state_d  = GNT_OPEN;
      rr_ptr_d = next_ch(grant, NUM_CH);
    end else if (any_valid && state_q == GNT_OPEN) begin
      state_d   = GNT_LOCKED;
      lock_ch_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= GNT_OPEN;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mc_req_fifo.sv
module tb_mc_req_fifo;
  import mc_req_fifo_pkg::*;

  localparam int NCH = 4;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  mc_req_fifo_if #(.NUM_CH(NCH)) bus ();

  mc_req_fifo #(
    .NUM_CH    (NCH),
    .DEPTH     (DEP),
    .AFULL_LVL (3)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  req_pkt_type sb [NCH][$];
  int          mc [NCH];
  logic [NCH-1:0] ovf_m;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.write_in = '0;
  endtask

  function automatic req_pkt_type mk(logic [7:0] id);
    req_pkt_type p;
    p.req_id = id;
    p.addr   = {8'h0, id, 8'hA5};
    p.is_wr  = id[0];
    return p;
  endfunction

  task automatic stage_write(int ch, logic [7:0] id);
    req_pkt_type p;
    p = mk(id);
    bus.write_in[ch]  = 1'b1;
    bus.input_req[ch] = p;
    if (mc[ch] < DEP) begin
      sb[ch].push_back(p);
      mc[ch]++;
    end else begin
      ovf_m[ch] = 1'b1;
    end
  endtask

  task automatic pop_expect(int ch, string tag);
    req_pkt_type exp;
    exp = (sb[ch].size() > 0) ? sb[ch].pop_front() : '0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_ch"},    64'(bus.out_ch),    64'(ch));
    chk({tag, "_data"},  64'(bus.output_req), 64'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (mc[ch] > 0) mc[ch]--;
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      sb[c].delete();
      mc[c] = 0;
    end
    ovf_m = '0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    clear_model();
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid),  64'(0));
    chk({tag, "_req"},   64'(bus.output_req), 64'(0));
    chk({tag, "_ch"},    64'(bus.out_ch),     64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_in  = '0;
    bus.input_req = '0;
    bus.out_ready = 1'b0;
    rst_b         = 1'b0;
    clear_model();
    tick();
    do_reset();

    // reset state
    chk_idle("rst");
    chk("rst_full",  64'(bus.fifo_full),    64'(0));
    chk("rst_afull", 64'(bus.fifo_afull),   64'(0));
    chk("rst_ovf",   64'(bus.overflow_err), 64'(0));

    // single write on ch2, held while out_ready=0
    stage_write(2, 8'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(bus.out_valid),         64'(1));
      chk("hold_ch",    64'(bus.out_ch),            64'(2));
      chk("hold_id",    64'(bus.output_req.req_id), 64'(5));
      tick();
    end
    pop_expect(2, "t1_pop");
    chk_idle("t1_end");

    // round robin over ch0, ch1, ch3
    do_reset();
    stage_write(0, 8'd20); stage_write(1, 8'd21); stage_write(3, 8'd23);
    tick();
    stage_write(0, 8'd24); stage_write(1, 8'd25); stage_write(3, 8'd27);
    tick();
    pop_expect(0, "rr0"); pop_expect(1, "rr1"); pop_expect(3, "rr2");
    pop_expect(0, "rr3"); pop_expect(1, "rr4"); pop_expect(3, "rr5");
    chk_idle("rr_end");

    // fill ch1 past full
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      stage_write(1, 8'(n));
      tick();
      chk("fill_afull", 64'(bus.fifo_afull[1]),  64'(n >= 3));
      chk("fill_full",  64'(bus.fifo_full[1]),   64'(n >= 4));
      chk("fill_ovf",   64'(bus.overflow_err),   64'(ovf_m));
    end
    for (int n = 1; n <= 4; n++) pop_expect(1, "fill_pop");
    chk("fill_ovf_sticky", 64'(bus.overflow_err), 64'(ovf_m));
    chk_idle("fill_end");

    // full channel popped and written in the same cycle
    do_reset();
    for (int n = 0; n < 4; n++) begin
      stage_write(1, 8'(10 + n));
      tick();
    end
    stage_write(1, 8'd14);
    pop_expect(1, "fpw_pop");
    chk("fpw_full",  64'(bus.fifo_full[1]),  64'(0));
    chk("fpw_afull", 64'(bus.fifo_afull[1]), 64'(1));
    chk("fpw_ovf",   64'(bus.overflow_err),  64'(ovf_m));
    for (int n = 0; n < 3; n++) pop_expect(1, "fpw_drain");
    chk_idle("fpw_end");

    // grant lock holds ch3 when ch0 arrives
    do_reset();
    stage_write(3, 8'd30);
    tick();
    chk("lock_ch_a", 64'(bus.out_ch), 64'(3));
    stage_write(0, 8'd31);
    tick();
    chk("lock_ch_b", 64'(bus.out_ch), 64'(3));
    tick();
    chk("lock_ch_c", 64'(bus.out_ch), 64'(3));
    pop_expect(3, "lock_pop3");
    pop_expect(0, "lock_pop0");
    chk_idle("lock_end");

    // reset mid-operation, then pointer wrap on ch2
    do_reset();
    stage_write(0, 8'd50); stage_write(2, 8'd52);
    for (int n = 0; n < 5; n++) begin
      stage_write(1, 8'(60 + n));
      tick();
    end
    chk("pre_full", 64'(bus.fifo_full),    64'(4'b0010));
    chk("pre_ovf",  64'(bus.overflow_err), 64'(ovf_m));
    rst_b             = 1'b0;
    bus.out_ready     = 1'b1;
    bus.write_in[3]   = 1'b1;
    bus.input_req[3]  = mk(8'd70);
    tick();
    bus.out_ready     = 1'b0;
    rst_b             = 1'b1;
    clear_model();
    chk_idle("mid_rst");
    chk("mid_rst_full",  64'(bus.fifo_full),    64'(0));
    chk("mid_rst_afull", 64'(bus.fifo_afull),   64'(0));
    chk("mid_rst_ovf",   64'(bus.overflow_err), 64'(0));
    for (int i = 0; i < 10; i++) begin
      stage_write(2, 8'(80 + i));
      if (i >= 2) pop_expect(2, "wrap_pop");
      else tick();
    end
    pop_expect(2, "wrap_drain");
    pop_expect(2, "wrap_drain");
    chk_idle("wrap_end");
    chk("wrap_ovf", 64'(bus.overflow_err), 64'(ovf_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
